// File: rtl/io_bus_arbiter.sv
// Two-master round-robin arbiter/sequencer for the shared I/O bus.
// Optional master lock: define IO_BUS_ARBITER_LOCK_EN.
`timescale 1ns/1ps
module io_bus_arbiter #(
    parameter int WAIT_CYCLES = 1,
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
`ifdef IO_BUS_ARBITER_LOCK_EN
    input  logic              m0_lock,
`endif
    output logic              m0_gnt,
    output logic              m0_done,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
`ifdef IO_BUS_ARBITER_LOCK_EN
    input  logic              m1_lock,
`endif
    output logic              m1_gnt,
    output logic              m1_done,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              bus_en,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              busy
);

    localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [3:0]        r_cnt;
    logic              r_owner;
    logic              r_last;
    logic              r_m0_gnt;
    logic              r_m1_gnt;
    logic              r_m0_done;
    logic              r_m1_done;
    logic [DATA_W-1:0] r_m0_rdata;
    logic [DATA_W-1:0] r_m1_rdata;
    logic              r_bus_en;
    logic              r_bus_we;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [DATA_W-1:0] r_bus_wdata;
    logic              r_busy;

    logic              w_any;
    logic              w_win;

`ifdef IO_BUS_ARBITER_LOCK_EN
    logic              r_lock_vld;
    logic              r_lock_id;
    logic              w_lock_req;
    logic              w_own_lock;

    assign w_lock_req = r_lock_id ? m1_req : m0_req;
    assign w_own_lock = r_owner ? m1_lock : m0_lock;
`endif

    // r_last holds the master served last; reset value 1 favours master 0
    always_comb begin
        w_any = m0_req | m1_req;
        w_win = m1_req & (~m0_req | ~r_last);
`ifdef IO_BUS_ARBITER_LOCK_EN
        if (r_lock_vld && w_lock_req) begin
            w_win = r_lock_id;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (w_any) w_next = S_ACCESS;
            S_ACCESS: if (r_cnt == 4'd0) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= 4'd0;
            r_owner     <= 1'b0;
            r_last      <= 1'b1;
            r_m0_gnt    <= 1'b0;
            r_m1_gnt    <= 1'b0;
            r_m0_done   <= 1'b0;
            r_m1_done   <= 1'b0;
            r_m0_rdata  <= '0;
            r_m1_rdata  <= '0;
            r_bus_en    <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_busy      <= 1'b0;
`ifdef IO_BUS_ARBITER_LOCK_EN
            r_lock_vld  <= 1'b0;
            r_lock_id   <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE: begin
`ifdef IO_BUS_ARBITER_LOCK_EN
                    if (r_lock_vld && !w_lock_req) begin
                        r_lock_vld <= 1'b0;
                    end
`endif
                    if (w_any) begin
                        r_owner     <= w_win;
                        r_m0_gnt    <= ~w_win;
                        r_m1_gnt    <= w_win;
                        r_bus_en    <= 1'b1;
                        r_busy      <= 1'b1;
                        r_cnt       <= LP_WAIT;
                        r_bus_we    <= w_win ? m1_we : m0_we;
                        r_bus_addr  <= w_win ? m1_addr : m0_addr;
                        r_bus_wdata <= w_win ? m1_wdata : m0_wdata;
                    end
                end
                S_ACCESS: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_bus_en  <= 1'b0;
                        r_bus_we  <= 1'b0;
                        r_m0_gnt  <= 1'b0;
                        r_m1_gnt  <= 1'b0;
                        r_m0_done <= ~r_owner;
                        r_m1_done <= r_owner;
                        if (!r_bus_we) begin
                            if (r_owner) r_m1_rdata <= bus_rdata;
                            else         r_m0_rdata <= bus_rdata;
                        end
                    end
                end
                S_DONE: begin
                    r_m0_done <= 1'b0;
                    r_m1_done <= 1'b0;
                    r_busy    <= 1'b0;
`ifdef IO_BUS_ARBITER_LOCK_EN
                    // a locking owner keeps its claim and leaves the pointer alone
                    r_lock_vld <= w_own_lock;
                    r_lock_id  <= r_owner;
                    if (!w_own_lock) begin
                        r_last <= r_owner;
                    end
`else
                    r_last <= r_owner;
`endif
                end
                default: begin
                end
            endcase
        end
    end

    assign m0_gnt    = r_m0_gnt;
    assign m1_gnt    = r_m1_gnt;
    assign m0_done   = r_m0_done;
    assign m1_done   = r_m1_done;
    assign m0_rdata  = r_m0_rdata;
    assign m1_rdata  = r_m1_rdata;
    assign bus_en    = r_bus_en;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign busy      = r_busy;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Self-checking bench for io_bus_arbiter: directed scenarios plus a
// randomized run against a transaction-phase reference model.
`timescale 1ns/1ps
module tb_io_bus_arbiter;

    localparam int W = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata, bus_rdata;
`ifdef IO_BUS_ARBITER_LOCK_EN
    logic        m0_lock, m1_lock;
`endif
    logic        m0_gnt, m0_done, m1_gnt, m1_done;
    logic        bus_en, bus_we, busy;
    logic [15:0] m0_rdata, m1_rdata, bus_addr, bus_wdata;
    logic        z_g0, z_d0, z_g1, z_d1, z_en, z_we, z_busy;
    logic [15:0] z_r0, z_r1, z_addr, z_wd;

    int n_cmp = 0;
    int n_err = 0;

    io_bus_arbiter #(.WAIT_CYCLES(W), .DATA_W(16), .ADDR_W(16)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
`ifdef IO_BUS_ARBITER_LOCK_EN
        .m0_lock(m0_lock),
`endif
        .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
`ifdef IO_BUS_ARBITER_LOCK_EN
        .m1_lock(m1_lock),
`endif
        .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata),
        .bus_en(bus_en), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .busy(busy)
    );

    io_bus_arbiter #(.WAIT_CYCLES(0), .DATA_W(16), .ADDR_W(16)) dut0 (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
`ifdef IO_BUS_ARBITER_LOCK_EN
        .m0_lock(m0_lock),
`endif
        .m0_gnt(z_g0), .m0_done(z_d0), .m0_rdata(z_r0),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
`ifdef IO_BUS_ARBITER_LOCK_EN
        .m1_lock(m1_lock),
`endif
        .m1_gnt(z_g1), .m1_done(z_d1), .m1_rdata(z_r1),
        .bus_en(z_en), .bus_we(z_we), .bus_addr(z_addr),
        .bus_wdata(z_wd), .bus_rdata(bus_rdata), .busy(z_busy)
    );

    always #5 clk = ~clk;

    logic [70:0] obs, zobs, eexp;
    assign obs  = {m0_gnt, m1_gnt, m0_done, m1_done, bus_en, bus_we, busy,
                   bus_addr, bus_wdata, m0_rdata, m1_rdata};
    assign zobs = {z_g0, z_g1, z_d0, z_d1, z_en, z_we, z_busy,
                   z_addr, z_wd, z_r0, z_r1};

    // Reference model: ph counts edges since the grant (-1 = idle)
    int          ph;
    bit          own, last;
    logic        e_g0, e_g1, e_d0, e_d1, e_en, e_we, e_busy;
    logic [15:0] e_addr, e_wd, e_r0, e_r1;
    assign eexp = {e_g0, e_g1, e_d0, e_d1, e_en, e_we, e_busy,
                   e_addr, e_wd, e_r0, e_r1};

    function automatic void model_step();
        if (reset) begin
            ph = -1; last = 1'b1; own = 1'b0;
            {e_g0, e_g1, e_d0, e_d1, e_en, e_we, e_busy} = '0;
            e_addr = '0; e_wd = '0; e_r0 = '0; e_r1 = '0;
            return;
        end
        if (ph < 0) begin
            if (m0_req || m1_req) begin
                own    = (m0_req && m1_req) ? !last : m1_req;
                ph     = 0;
                e_g0   = !own; e_g1 = own;
                e_en   = 1'b1; e_busy = 1'b1;
                e_we   = own ? m1_we : m0_we;
                e_addr = own ? m1_addr : m0_addr;
                e_wd   = own ? m1_wdata : m0_wdata;
            end
        end else begin
            ph++;
            if (ph == W + 1) begin
                if (!e_we) begin
                    if (own) e_r1 = bus_rdata;
                    else     e_r0 = bus_rdata;
                end
                e_g0 = 1'b0; e_g1 = 1'b0; e_en = 1'b0; e_we = 1'b0;
                e_d0 = !own; e_d1 = own;
            end else if (ph == W + 2) begin
                e_d0 = 1'b0; e_d1 = 1'b0; e_busy = 1'b0;
                last = own; ph = -1;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        n_cmp++;
        if (obs !== '0) begin
            n_err++; $display("FAIL reset_outputs got=%h exp=0", obs);
        end
        n_cmp++;
        if (zobs !== '0) begin
            n_err++; $display("FAIL reset_outputs_w0 got=%h exp=0", zobs);
        end
        reset = 1'b0;
    endtask

    task automatic test_write();
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 16'hFFFF; m0_wdata = 16'h00A5;
        tick();
        n_cmp++;
        if ({m0_gnt, m1_gnt, bus_en, bus_we, busy, m0_done, bus_addr, bus_wdata}
            !== {6'b101110, 16'hFFFF, 16'h00A5}) begin
            n_err++; $display("FAIL wr_cycle1 got=%b_%h_%h exp=101110_ffff_00a5",
                {m0_gnt, m1_gnt, bus_en, bus_we, busy, m0_done}, bus_addr, bus_wdata);
        end
        m0_req = 1'b0; m0_addr = 16'h0000; m0_wdata = 16'h1111;
        tick();
        n_cmp++;
        if ({m0_gnt, bus_en, bus_we, m0_done, bus_addr, bus_wdata}
            !== {4'b1110, 16'hFFFF, 16'h00A5}) begin
            n_err++; $display("FAIL wr_cycle2 got=%b_%h_%h exp=1110_ffff_00a5",
                {m0_gnt, bus_en, bus_we, m0_done}, bus_addr, bus_wdata);
        end
        tick();
        n_cmp++;
        if ({m0_gnt, bus_en, bus_we, m0_done, busy} !== 5'b00011) begin
            n_err++; $display("FAIL wr_done got=%b exp=00011",
                {m0_gnt, bus_en, bus_we, m0_done, busy});
        end
        n_cmp++;
        if ({m1_gnt, m1_done, m1_rdata, m0_rdata} !== '0) begin
            n_err++; $display("FAIL wr_m1_quiet got=%b_%h_%h exp=00_0000_0000",
                {m1_gnt, m1_done}, m1_rdata, m0_rdata);
        end
        tick();
        n_cmp++;
        if ({m0_done, busy, bus_en} !== 3'b000) begin
            n_err++; $display("FAIL wr_idle got=%b exp=000", {m0_done, busy, bus_en});
        end
    endtask

    task automatic test_read();
        bus_rdata = 16'h0009;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'hFFFD;
        tick();
        n_cmp++;
        if ({m1_gnt, m0_gnt, bus_en, bus_we, bus_addr} !== {4'b1010, 16'hFFFD}) begin
            n_err++; $display("FAIL rd_grant got=%b_%h exp=1010_fffd",
                {m1_gnt, m0_gnt, bus_en, bus_we}, bus_addr);
        end
        m1_req = 1'b0;
        tick(); tick();
        n_cmp++;
        if ({m1_done, m1_rdata, m0_rdata} !== {1'b1, 16'h0009, 16'h0000}) begin
            n_err++; $display("FAIL rd_done got=%b_%h_%h exp=1_0009_0000",
                m1_done, m1_rdata, m0_rdata);
        end
        bus_rdata = 16'h7777;
        tick();
        n_cmp++;
        if ({m1_done, m1_rdata} !== {1'b0, 16'h0009}) begin
            n_err++; $display("FAIL rd_hold got=%b_%h exp=0_0009", m1_done, m1_rdata);
        end
    endtask

    task automatic test_round_robin();
        int  who[$];
        int  at[$];
        int  overlap = 0;
        bit  prev = 1'b0;
        m0_req = 1'b1; m1_req = 1'b1; m0_we = 1'b1; m1_we = 1'b1;
        for (int c = 0; c < 30 && who.size() < 3; c++) begin
            tick();
            if (m0_gnt && m1_gnt) overlap++;
            if ((m0_gnt || m1_gnt) && !prev) begin
                who.push_back(int'(m1_gnt));
                at.push_back(c);
            end
            prev = m0_gnt | m1_gnt;
        end
        m0_req = 1'b0; m1_req = 1'b0;
        for (int c = 0; c < 10 && busy; c++) begin
            tick();
            if (m0_gnt && m1_gnt) overlap++;
        end
        n_cmp++;
        if (who.size() != 3) begin
            n_err++; $display("FAIL rr_count got=%0d exp=3", who.size());
        end else begin
            n_cmp++;
            if (who[0] != 0 || who[1] != 1 || who[2] != 0) begin
                n_err++; $display("FAIL rr_order got=%0d%0d%0d exp=010",
                    who[0], who[1], who[2]);
            end
            n_cmp++;
            if (at[1] - at[0] != W + 3 || at[2] - at[1] != W + 3) begin
                n_err++; $display("FAIL rr_spacing got=%0d,%0d exp=%0d",
                    at[1] - at[0], at[2] - at[1], W + 3);
            end
        end
        n_cmp++;
        if (overlap != 0) begin
            n_err++; $display("FAIL rr_onehot got=%0d exp=0", overlap);
        end
    endtask

    task automatic test_back_to_back_w0();
        int  at[$];
        int  en_cyc = 0;
        int  bad = 0;
        bit  prev = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m0_req = 1'b1; m0_we = 1'b0; m1_req = 1'b0;
        for (int c = 0; c < 16; c++) begin
            tick();
            bus_rdata = 16'($urandom);
            if (z_g0 && !prev) at.push_back(c);
            prev = z_g0;
            if (z_en) en_cyc++;
        end
        m0_req = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        for (int i = 1; i < at.size(); i++) begin
            if (at[i] - at[i-1] != 3) bad++;
        end
        n_cmp++;
        if (at.size() != 6) begin
            n_err++; $display("FAIL w0_grants got=%0d exp=6", at.size());
        end
        n_cmp++;
        if (en_cyc != at.size()) begin
            n_err++; $display("FAIL w0_en_cycles got=%0d exp=%0d", en_cyc, at.size());
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++; $display("FAIL w0_spacing got=%0d_bad exp=0", bad);
        end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 16'h1234;
        tick();
        m0_req = 1'b0;
        for (int c = 0; c < W + 2; c++) tick();
        m0_req = 1'b1;
        tick();
        n_cmp++;
        if ({m0_gnt, bus_en} !== 2'b11) begin
            n_err++; $display("FAIL mid_grant got=%b exp=11", {m0_gnt, bus_en});
        end
        reset = 1'b1;
        tick();
        n_cmp++;
        if (obs !== '0) begin
            n_err++; $display("FAIL mid_reset got=%h exp=0", obs);
        end
        reset = 1'b0; m0_req = 1'b1; m1_req = 1'b1;
        tick();
        n_cmp++;
        if ({m0_gnt, m1_gnt, m0_done, m1_done} !== 4'b1000) begin
            n_err++; $display("FAIL mid_regrant got=%b exp=1000",
                {m0_gnt, m1_gnt, m0_done, m1_done});
        end
        m0_req = 1'b0; m1_req = 1'b0;
        for (int c = 0; c < 6; c++) tick();
    endtask

`ifdef IO_BUS_ARBITER_LOCK_EN
    task automatic test_lock();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m1_req = 1'b1; m1_we = 1'b1; m1_lock = 1'b1;
        tick(); tick(); tick();
        m0_req = 1'b1; m0_we = 1'b1;
        tick(); tick();
        n_cmp++;
        if ({m1_gnt, m0_gnt} !== 2'b10) begin
            n_err++; $display("FAIL lock_hold got=%b exp=10", {m1_gnt, m0_gnt});
        end
        tick(); tick();
        m1_req = 1'b0;
        tick(); tick();
        n_cmp++;
        if ({m1_gnt, m0_gnt} !== 2'b01) begin
            n_err++; $display("FAIL lock_release got=%b exp=01", {m1_gnt, m0_gnt});
        end
        m0_req = 1'b0; m1_lock = 1'b0;
        for (int c = 0; c < 6; c++) tick();
    endtask
`endif

    task automatic test_random();
        int onehot_bad = 0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m0_req = 1'b0; m1_req = 1'b0;
        for (int c = 0; c < 600; c++) begin
            tick();
            n_cmp++;
            if (obs !== eexp) begin
                n_err++; $display("FAIL rand_cycle%0d got=%h exp=%h", c, obs, eexp);
            end
            if (m0_gnt && m1_gnt) onehot_bad++;
            reset = ($urandom_range(0, 99) == 0);
            bus_rdata = 16'($urandom);
            if (e_d0) begin
                if ($urandom_range(0, 2) != 0) m0_req = 1'b0;
                else begin
                    m0_we = 1'($urandom); m0_addr = 16'($urandom); m0_wdata = 16'($urandom);
                end
            end else if (!m0_req) begin
                if ($urandom_range(0, 3) == 0) begin
                    m0_req = 1'b1;
                    m0_we = 1'($urandom); m0_addr = 16'($urandom); m0_wdata = 16'($urandom);
                end
            end else if (!(ph >= 0 && own == 1'b0)) begin
                if ($urandom_range(0, 15) == 0) m0_req = 1'b0;
            end else begin
                m0_we = 1'($urandom); m0_addr = 16'($urandom); m0_wdata = 16'($urandom);
            end
            if (e_d1) begin
                if ($urandom_range(0, 2) != 0) m1_req = 1'b0;
                else begin
                    m1_we = 1'($urandom); m1_addr = 16'($urandom); m1_wdata = 16'($urandom);
                end
            end else if (!m1_req) begin
                if ($urandom_range(0, 3) == 0) begin
                    m1_req = 1'b1;
                    m1_we = 1'($urandom); m1_addr = 16'($urandom); m1_wdata = 16'($urandom);
                end
            end else if (!(ph >= 0 && own == 1'b1)) begin
                if ($urandom_range(0, 15) == 0) m1_req = 1'b0;
            end else begin
                m1_we = 1'($urandom); m1_addr = 16'($urandom); m1_wdata = 16'($urandom);
            end
        end
        reset = 1'b0;
        n_cmp++;
        if (onehot_bad != 0) begin
            n_err++; $display("FAIL rand_onehot got=%0d exp=0", onehot_bad);
        end
    endtask

    initial begin
        reset = 1'b1;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
        bus_rdata = '0;
`ifdef IO_BUS_ARBITER_LOCK_EN
        m0_lock = 1'b0; m1_lock = 1'b0;
`endif
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_back_to_back_w0();
        test_reset_mid();
`ifdef IO_BUS_ARBITER_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/io_bus_arbiter.md
Name: io_bus_arbiter

Overview:
Two-master arbiter and sequencer for the shared 16-bit I/O/memory bus that feeds the I/O manager.
- Master 0 is the CPU data port; master 1 is a secondary requester such as a boot loader or DMA.
- The block grants the bus round-robin and drives the address, write strobe and write data for a fixed access window. It captures read data and returns a one-cycle done pulse to the owner.
- It sits between the masters and the I/O manager's addr/oe/data interface.

Parameters:
- WAIT_CYCLES, 1, extra bus cycles held per transfer beyond the first. Legal range 0..15; held in a 4-bit counter.
- DATA_W, 16, data width.
- ADDR_W, 16, address width.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- m0_req  input  1  master 0 transfer request; held until m0_done.
- m0_we  input  1  master 0 direction: 1 = write, 0 = read.
- m0_addr  input  ADDR_W  master 0 address.
- m0_wdata  input  DATA_W  master 0 write data.
- m0_gnt  output  1  master 0 owns the bus.
- m0_done  output  1  one-cycle transfer-complete pulse to master 0.
- m0_rdata  output  DATA_W  read data returned to master 0.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_done, m1_rdata: same as master 0, for master 1.
- bus_en  output  1  bus access active.
- bus_we  output  1  bus write strobe; drives the I/O manager oe.
- bus_addr  output  ADDR_W  bus address.
- bus_wdata  output  DATA_W  bus write data.
- bus_rdata  input  DATA_W  bus read data.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- All outputs are registered.
- Reset values: state IDLE; every gnt, done, bus_en, bus_we and busy output is 0; bus_addr, bus_wdata, m0_rdata and m1_rdata are 0; the priority pointer favours master 0.
- States: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - If no request, stay in IDLE.
  - If exactly one req is high, that master wins.
  - If both are high, the master not served last wins; the pointer toggles to the winner.
  - On the transition edge: latch the winner's addr, we and wdata into bus_addr, bus_we and bus_wdata. Set the winner's gnt, bus_en and busy. Load the counter with WAIT_CYCLES. Go to ACCESS.
- ACCESS:
  - bus_en and bus signals are held stable for WAIT_CYCLES+1 cycles.
  - While the counter is nonzero, decrement it.
  - When the counter is 0: for a read, capture bus_rdata into the owner's rdata; go to DONE. Clear bus_en, bus_we and gnt on that edge.
- DONE:
  - The owner's done is high for exactly one cycle; busy stays 1.
  - Next edge: done is cleared and the state returns to IDLE.
- Latency:
  - A request sampled at edge k gives gnt and bus_en from edge k.
  - done is high in the cycle after edge k+WAIT_CYCLES+1.
  - Minimum spacing between consecutive grants is WAIT_CYCLES+3 cycles.
- rdata holds its last captured value until the next read by that master. Writes do not modify rdata.
- A req dropped after grant does not abort the transfer; done still pulses.
- A req dropped before it is sampled in IDLE is ignored.
- A master's command inputs are not sampled after the grant edge.
- A master whose req is still high at DONE is re-arbitrated in IDLE against the other master. Fairness comes from the pointer.
- Reset mid-ACCESS or mid-DONE: next edge goes to IDLE and all outputs take their reset values. No done pulse is produced for the aborted transfer; the pointer returns to master 0.
- gnt is one-hot or zero at all times; m0_gnt and m1_gnt are never both high.

Optional Feature:
- Macro: IO_BUS_ARBITER_LOCK_EN.
- When defined:
  - Adds inputs m0_lock and m1_lock (1 bit each).
  - If the owner's lock is high in DONE, the lock is recorded for that master and the pointer is not toggled.
  - In the next IDLE, the locked master wins whenever its req is high, regardless of the other req.
  - If the locked master's req is low in IDLE, the lock is released and normal round-robin applies.
  - Reset clears the lock.
- When undefined: no lock ports exist and arbitration is pure round-robin.

Test Plan:
1. Reset, then m0 write with addr 16'hFFFF, wdata 16'h00A5, WAIT_CYCLES=1 -> bus_en, bus_we and m0_gnt are high for 2 cycles with bus_addr=FFFF and bus_wdata=00A5; m0_done pulses 1 cycle later; m1 outputs stay 0.
2. m1 read of addr 16'hFFFD with bus_rdata=16'h0009 -> m1_rdata=0009 after done; m0_rdata is unchanged.
3. m0_req and m1_req asserted together, held for 3 transfers -> grant order m0, m1, m0; m0_gnt and m1_gnt are never both high.
4. WAIT_CYCLES=0 back-to-back m0 reads -> bus_en is high 1 cycle per transfer; grants are 3 cycles apart.
5. reset asserted during ACCESS -> the next cycle is IDLE with all outputs 0, no done pulse, and the next simultaneous request is granted to m0.
6. (LOCK_EN) m1 transfer with m1_lock=1, then m0 and m1 request together -> m1 is granted again. With m1_req low in IDLE, m0 is granted next.
